// File: rtl/mode_sequencer.sv
// Debounced mode cycler with tick divider, per-mode activity
// counter and step-motor phase sequencer.
module mode_sequencer #(
  parameter int NUM_MODES    = 3,
  parameter int MODE_W       = 2,
  parameter int DEBOUNCE_CYC = 20,
  parameter int TICK_DIV     = 10,
  parameter int MOTOR_MODE   = 2,
  parameter int HALF_STEP    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode_btn,
  input  logic                 dir,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] mode_onehot,
  output logic                 mode_chg,
  output logic                 tick,
  output logic [7:0]           act_cnt,
  output logic [3:0]           step_motor
);

  localparam int DBW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int DIVW = $clog2(TICK_DIV);

  localparam logic [DBW-1:0]    DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [DIVW-1:0]   DIV_LAST  = DIVW'(TICK_DIV - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MOT_MODE  = MODE_W'(MOTOR_MODE);
  localparam logic [2:0]        PH_MASK   = (HALF_STEP != 0) ? 3'b111 : 3'b011;

  logic [1:0]        sync_q;
  logic              db_q;
  logic [DBW-1:0]    dbcnt_q;
  logic [DIVW-1:0]   div_q;
  logic              tick_q;
  logic [MODE_W-1:0] mode_q;
  logic              chg_q;
  logic [7:0]        act_q;
  logic [2:0]        phase_q;

  logic              sync_lvl;
  logic              db_flip;
  logic              adv;
  logic              tick_d;
  logic              in_motor;
  logic [MODE_W-1:0] mode_d;
  logic [2:0]        phase_d;
  logic [3:0]        pat;

  always_comb begin
    sync_lvl = sync_q[1];
    db_flip  = (sync_lvl != db_q) && (dbcnt_q == DB_LAST);
    // only an accepted rising level advances the mode
    adv      = db_flip && sync_lvl;
    tick_d   = (div_q == DIV_LAST);
    in_motor = (mode_q == MOT_MODE);
    mode_d   = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
    phase_d  = dir ? (phase_q + 3'd1) : (phase_q - 3'd1);
    phase_d  = phase_d & PH_MASK;
  end

  always_comb begin
    pat = 4'b0000;
    if (HALF_STEP != 0) begin
      case (phase_q)
        3'd0:    pat = 4'b1000;
        3'd1:    pat = 4'b1100;
        3'd2:    pat = 4'b0100;
        3'd3:    pat = 4'b0110;
        3'd4:    pat = 4'b0010;
        3'd5:    pat = 4'b0011;
        3'd6:    pat = 4'b0001;
        default: pat = 4'b1001;
      endcase
    end else begin
      case (phase_q[1:0])
        2'd0:    pat = 4'b1100;
        2'd1:    pat = 4'b0110;
        2'd2:    pat = 4'b0011;
        default: pat = 4'b1001;
      endcase
    end
  end

  always_comb begin
    mode_onehot = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      mode_onehot[i] = (mode_q == MODE_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      db_q    <= 1'b0;
      dbcnt_q <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      mode_q  <= '0;
      chg_q   <= 1'b0;
      act_q   <= '0;
      phase_q <= '0;
    end else begin
      sync_q <= {sync_q[0], mode_btn};
      if (sync_lvl == db_q) begin
        dbcnt_q <= '0;
      end else if (db_flip) begin
        db_q    <= sync_lvl;
        dbcnt_q <= '0;
      end else begin
        dbcnt_q <= dbcnt_q + 1'b1;
      end
      div_q  <= tick_d ? '0 : div_q + 1'b1;
      tick_q <= tick_d;
      chg_q  <= adv;
      if (adv) mode_q <= mode_d;
      // a mode change on a tick edge still clears the counters
      if (adv) begin
        act_q <= '0;
      end else if (tick_d) begin
        act_q <= act_q + 8'd1;
      end
      if (adv) begin
        phase_q <= '0;
      end else if (tick_d && in_motor) begin
        phase_q <= phase_d;
      end
    end
  end

  assign mode       = mode_q;
  assign mode_chg   = chg_q;
  assign tick       = tick_q;
  assign act_cnt    = act_q;
  assign step_motor = in_motor ? pat : 4'b0000;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench: full-step and half-step instances share the
// button and reset; a monitor pops expectations on mode_chg/tick.
module tb_mode_sequencer;

  typedef struct {
    int         mode;
    logic [3:0] sf;
    logic [3:0] sh;
    int         cyc;
    bit         at_tick;
  } chg_t;

  typedef struct {
    logic [3:0] sf;
    logic [3:0] sh;
  } mot_t;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       dir_f;
  logic       dir_h;
  logic [1:0] mode_f, mode_h;
  logic [2:0] oh_f, oh_h;
  logic       chg_f, chg_h;
  logic       tick_f, tick_h;
  logic [7:0] act_f, act_h;
  logic [3:0] stp_f, stp_h;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mot_lo = 0;
  int mot_hi = 0;

  chg_t q_chg[$];
  mot_t q_mot[$];

  mode_sequencer #(.HALF_STEP(0)) dut_f (
    .clk(clk), .rst(rst), .mode_btn(btn), .dir(dir_f),
    .mode(mode_f), .mode_onehot(oh_f), .mode_chg(chg_f),
    .tick(tick_f), .act_cnt(act_f), .step_motor(stp_f)
  );

  mode_sequencer #(.HALF_STEP(1)) dut_h (
    .clk(clk), .rst(rst), .mode_btn(btn), .dir(dir_h),
    .mode(mode_h), .mode_onehot(oh_h), .mode_chg(chg_h),
    .tick(tick_h), .act_cnt(act_h), .step_motor(stp_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] onehot(input int m);
    logic [2:0] v;
    v = 3'b001 << m;
    return v;
  endfunction

  always @(negedge clk) begin
    chg_t e;
    mot_t m;
    bit   exp_t;
    int   lat_cyc;
    if (rst) begin
      exp_t = (cyc % 10 == 0) && (cyc > 0);
      if (tick_f || exp_t) chk("tick", int'(tick_f), int'(exp_t));
      if (chg_f) begin
        if (q_chg.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chg mode %0d cyc %0d", mode_f, cyc);
        end else begin
          e = q_chg.pop_front();
          chk("chg_mode", int'(mode_f), e.mode);
          chk("chg_mode_h", int'(mode_h), e.mode);
          chk("chg_h", int'(chg_h), 1);
          chk("chg_onehot", int'(oh_f), int'(onehot(e.mode)));
          chk("chg_onehot_h", int'(oh_h), int'(onehot(e.mode)));
          chk("chg_act", int'(act_f), 0);
          chk("chg_step_f", int'(stp_f), int'(e.sf));
          chk("chg_step_h", int'(stp_h), int'(e.sh));
          lat_cyc = (cyc >= e.cyc - 1 && cyc <= e.cyc + 1) ? e.cyc : cyc;
          chk("chg_latency", lat_cyc, e.cyc);
          if (e.at_tick) chk("chg_on_tick", int'(tick_f), 1);
        end
      end
      if (tick_f && cyc > mot_lo && cyc < mot_hi) begin
        if (q_mot.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_motor_tick cyc %0d", cyc);
        end else begin
          m = q_mot.pop_front();
          chk("motor_f", int'(stp_f), int'(m.sf));
          chk("motor_h", int'(stp_h), int'(m.sh));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_mod(input int m);
    for (int i = 0; i < 10 && (cyc % 10) != m; i++) @(negedge clk);
  endtask

  task automatic press(input int m, input bit at_tick,
                       input logic [3:0] sf, input logic [3:0] sh);
    chg_t e;
    e.mode = m;
    e.sf = sf;
    e.sh = sh;
    e.cyc = cyc + 22;
    e.at_tick = at_tick;
    q_chg.push_back(e);
    btn = 1'b1;
    step(50);
    btn = 1'b0;
    step(50);
  endtask

  task automatic chk_reset_vals();
    chk("rst_mode", int'(mode_f), 0);
    chk("rst_mode_h", int'(mode_h), 0);
    chk("rst_onehot", int'(oh_f), 1);
    chk("rst_chg", int'(chg_f), 0);
    chk("rst_tick", int'(tick_f), 0);
    chk("rst_act", int'(act_f), 0);
    chk("rst_step_f", int'(stp_f), 0);
    chk("rst_step_h", int'(stp_h), 0);
  endtask

  initial begin
    logic [3:0] mf[7];
    logic [3:0] mh[7];
    mot_t m;
    chg_t e;
    int c;
    mf = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b0110};
    mh = '{4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100};
    rst = 1'b0;
    btn = 1'b0;
    dir_f = 1'b1;
    dir_h = 1'b0;
    step(3);
    chk_reset_vals();
    rst = 1'b1;
    step(30);
    chk("act_30", int'(act_f), 3);
    chk("act_30_h", int'(act_h), 3);
    chk("idle_step", int'(stp_f), 0);

    press(1, 1'b0, 4'b0000, 4'b0000);
    press(2, 1'b0, 4'b1100, 4'b1000);
    press(0, 1'b0, 4'b0000, 4'b0000);

    foreach (mf[i]) begin
      c = (i == 0) ? 5 : (i == 1) ? 10 : 19;
      if (i < 3) begin
        btn = 1'b1;
        step(c);
        btn = 1'b0;
        step(30);
      end
    end
    chk("glitch_mode", int'(mode_f), 0);

    e.mode = 1;
    e.sf = 4'b0000;
    e.sh = 4'b0000;
    e.cyc = cyc + 22;
    e.at_tick = 1'b0;
    q_chg.push_back(e);
    btn = 1'b1;
    step(20);
    btn = 1'b0;
    step(50);

    to_mod(3);
    c = cyc;
    e.mode = 2;
    e.sf = 4'b1100;
    e.sh = 4'b1000;
    e.cyc = c + 22;
    q_chg.push_back(e);
    for (int i = 0; i < 7; i++) begin
      m.sf = mf[i];
      m.sh = mh[i];
      q_mot.push_back(m);
    end
    mot_lo = c + 22;
    mot_hi = c + 95;
    btn = 1'b1;
    step(50);
    btn = 1'b0;
    step(30);
    dir_f = 1'b0;
    step(20);
    mot_hi = 0;
    dir_f = 1'b1;

    press(0, 1'b0, 4'b0000, 4'b0000);
    press(1, 1'b0, 4'b0000, 4'b0000);
    to_mod(8);
    press(2, 1'b1, 4'b1100, 4'b1000);

    step(13);
    btn = 1'b1;
    step(10);
    rst = 1'b0;
    btn = 1'b0;
    #1;
    chk_reset_vals();
    step(1);
    rst = 1'b1;
    step(80);
    chk("post_rst_mode", int'(mode_f), 0);
    chk("post_rst_step_f", int'(stp_f), 0);
    chk("post_rst_step_h", int'(stp_h), 0);

    chk("chg_queue_empty", q_chg.size(), 0);
    chk("mot_queue_empty", q_mot.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Parametrised successor to the single-button mode controller. It synchronises and debounces the raw mode button and cycles through NUM_MODES modes, with wrap-around. It also generates a divided tick, a per-mode activity counter, and a step-motor phase sequencer with full/half-step and direction. It runs on the 1 kHz board clock and feeds the LED, 7-segment, LCD and motor output stages; the button is never used as a clock.

Parameters:
NUM_MODES, 3, number of modes (>=2); mode counts 0..NUM_MODES-1
MODE_W, 2, width of mode output; must satisfy 2**MODE_W >= NUM_MODES
DEBOUNCE_CYC, 20, consecutive equal synchronised samples needed to accept a new button level (20 ms at 1 kHz)
TICK_DIV, 10, clk cycles per tick (1 kHz -> 100 Hz); >=2
MOTOR_MODE, 2, mode index in which the motor runs; < NUM_MODES
HALF_STEP, 0, 0 = 4-phase full-step table, 1 = 8-phase half-step table

Ports:
clk  input  1  board clock (1 kHz)
rst  input  1  asynchronous, active-low reset
mode_btn  input  1  raw mode push-button, asynchronous, active high
dir  input  1  motor direction: 1 forward, 0 reverse; sampled on tick
mode  output  MODE_W  current mode index
mode_onehot  output  NUM_MODES  one-hot decode of mode
mode_chg  output  1  one-cycle pulse on the cycle mode updates
tick  output  1  one-cycle pulse every TICK_DIV clk cycles
act_cnt  output  8  ticks elapsed in the current mode
step_motor  output  4  motor coil drive pattern

Behaviour:
- Reset (rst=0, async) values:
  - mode=0, mode_onehot=1, mode_chg=0, tick=0, act_cnt=0, step_motor=4'b0000.
  - Sync flops=0, debounced level=0, debounce counter=0, divider=0, phase index=0.
- Button synchroniser: two-flop synchroniser on mode_btn.
- Debounce:
  - The counter increments while the synchronised level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1, the debounced level takes the new value and the counter clears.
  - Any pulse shorter than DEBOUNCE_CYC cycles is ignored.
- Mode advance:
  - Triggered only by a rising edge of the debounced level; release does nothing.
  - mode <= (mode==NUM_MODES-1) ? 0 : mode+1.
  - mode, mode_onehot and mode_chg update on the same edge.
  - Latency: DEBOUNCE_CYC+2 cycles from the sampled button rise to the mode change (+-1 cycle sampling uncertainty).
- A button held high through reset release counts as a press: mode advances once after DEBOUNCE_CYC+2 cycles.
- Divider / tick:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 exactly in the cycle after the counter holds TICK_DIV-1 (registered output).
  - Never reset by mode changes.
- act_cnt:
  - Increments on tick and wraps from 255 to 0.
  - Clears to 0 on mode_chg.
  - Simultaneous tick and mode_chg: clear wins, act_cnt=0.
- Motor:
  - Full-step table, index 0..3: 1100, 0110, 0011, 1001.
  - Half-step table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - step_motor = table[phase] while mode==MOTOR_MODE, otherwise 0000.
  - Phase clears to 0 on mode_chg, so entering MOTOR_MODE outputs table[0] in the same cycle mode updates.
  - On tick in MOTOR_MODE, phase steps +1 if dir=1, -1 if dir=0, wrapping modulo the table length.
  - Simultaneous tick and mode_chg: phase=0.
- All outputs are registered except mode_onehot and step_motor, which decode combinationally from registered state.
- rst asserted mid-operation: all state returns to reset values immediately; no partial button press survives.

Test Plan:
1. Reset release with mode_btn=0 -> mode=0, mode_onehot=3'b001, step_motor=0000; tick pulses at cycles 10, 20, 30...; act_cnt reaches 3 after 30 cycles.
2. mode_btn high 50 cycles, low 50, repeated 3 times -> mode goes 1, 2, 0; each change comes with one mode_chg pulse about 22 cycles after the press; act_cnt=0 on each change.
3. mode_btn glitches of 5, 10 and 19 cycles separated by 30-cycle lows -> mode stays 0, no mode_chg.
4. Enter mode 2 with HALF_STEP=0, dir=1 -> step_motor=1100 immediately, then 0110, 0011, 1001, 1100 on successive ticks. Flip dir=0 at pattern 0011 -> next tick gives 0110.
5. HALF_STEP=1, dir=0, enter mode 2 -> 1000, then 1001, 0001, 0011 on ticks. Advance to mode 0 -> step_motor=0000. Re-enter mode 2 -> 1000.
6. Press debounced so mode_chg lands on a tick cycle -> act_cnt=0, not 1. Assert rst for 1 cycle mid-debounce and mid-motor -> all outputs return to reset values and no mode change follows.
